// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline-stage registers, the decoder and the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned CW_DEF   = 10;
  localparam int unsigned DW_DEF   = 133;
  localparam int unsigned CNTW_DEF = 16;

  // Control-bundle bit positions
  localparam int unsigned CTRL_SHIFT    = 0;
  localparam int unsigned CTRL_ALUIMM   = 1;
  localparam int unsigned CTRL_ALUC_LSB = 2;
  localparam int unsigned CTRL_ALUC_MSB = 5;
  localparam int unsigned CTRL_JAL      = 6;
  localparam int unsigned CTRL_WMEM     = 7;
  localparam int unsigned CTRL_M2REG    = 8;
  localparam int unsigned CTRL_WREG     = 9;

endpackage

// File: rtl/pipe_slot.sv
// One control+data holding register; cclr zeroes only the control half so a squashed slot becomes a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          load,
  input  logic          cclr,
  input  logic [CW-1:0] d_ctrl,
  input  logic [DW-1:0] d_data,
  output logic [CW-1:0] q_ctrl,
  output logic [DW-1:0] q_data
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)     q_ctrl <= '0;
    else if (cclr) q_ctrl <= '0;
    else if (load) q_ctrl <= d_ctrl;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)     q_data <= '0;
    else if (load) q_data <= d_data;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: two-entry skid buffer, registered in_ready,
// synchronous flush and a saturating bubble counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_ctrl,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ctrl,
  output logic [DW-1:0]   out_data,
  output logic [CNTW-1:0] bubble_cnt
);

  state_t        state, state_nxt;
  logic          accept, emit;
  logic          main_load, main_cclr, skid_load, use_skid;
  logic [CW-1:0] skid_ctrl, main_d_ctrl;
  logic [DW-1:0] skid_data, main_d_data;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !emit)      state_nxt = TWO;
          else if (!accept && emit) state_nxt = EMPTY;
        end
        TWO:     if (emit) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Slot control: main refills from skid only when draining TWO; main ctrl clears whenever it goes empty
  always_comb begin
    main_load = 1'b0;
    main_cclr = 1'b0;
    skid_load = 1'b0;
    use_skid  = 1'b0;
    if (flush) begin
      main_cclr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_load = accept;
        ONE: begin
          main_load = accept & emit;
          skid_load = accept & ~emit;
          main_cclr = emit & ~accept;
        end
        TWO: begin
          main_load = emit;
          use_skid  = 1'b1;
        end
        default: main_cclr = 1'b1;
      endcase
    end
  end

  assign main_d_ctrl = use_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = use_skid ? skid_data : in_data;

  pipe_slot #(.CW(CW), .DW(DW)) u_main (
    .clk    (clk),
    .clrn   (clrn),
    .load   (main_load),
    .cclr   (main_cclr),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (out_ctrl),
    .q_data (out_data)
  );

  pipe_slot #(.CW(CW), .DW(DW)) u_skid (
    .clk    (clk),
    .clrn   (clrn),
    .load   (skid_load),
    .cclr   (1'b0),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  // Handshake flags are registered from the next state so in_ready never depends on out_ready combinationally
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      bubble_cnt <= '0;
    else if (out_ready && !out_valid && (bubble_cnt != {CNTW{1'b1}}))
      bubble_cnt <= bubble_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand sequences and a queue-based random reference.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         clrn;
  logic         flush, in_valid, out_ready;
  logic [9:0]   in_ctrl;
  logic [132:0] in_data;
  logic         in_ready, out_valid;
  logic [9:0]   out_ctrl;
  logic [132:0] out_data;
  logic [15:0]  bubble_cnt;

  logic         flush2, in_valid2, out_ready2;
  logic [9:0]   in_ctrl2;
  logic [132:0] in_data2;
  logic         in_ready2, out_valid2;
  logic [9:0]   out_ctrl2;
  logic [132:0] out_data2;
  logic [2:0]   bubble_cnt2;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CW(10), .DW(133), .CNTW(16)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CW(10), .DW(133), .CNTW(3)) dut_sat (
    .clk(clk), .clrn(clrn), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_ctrl(in_ctrl2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .bubble_cnt(bubble_cnt2)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Reference model: the stage as an ordered queue of at most two beats
  typedef struct packed {
    logic [9:0]   c;
    logic [132:0] d;
  } beat_t;
  beat_t       mq[$];
  int unsigned mcnt;

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [9:0] c, input logic [132:0] d,
                            input logic ordy, input logic fl);
    int sz;
    sz = mq.size();
    if (fl) mq.delete();
    else begin
      if (sz > 0 && ordy) void'(mq.pop_front());
      if (iv && sz < 2) mq.push_back('{c, d});
    end
    if (ordy && sz == 0 && mcnt != 65535) mcnt++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out_valid"}, 133'(out_valid), 133'(mq.size() > 0));
    chk({tag, " out_ctrl"}, 133'(out_ctrl), (mq.size() > 0) ? 133'(mq[0].c) : 133'(0));
    if (mq.size() > 0) chk({tag, " out_data"}, out_data, mq[0].d);
    chk({tag, " in_ready"}, 133'(in_ready), 133'(mq.size() < 2));
    chk({tag, " bubble_cnt"}, 133'(bubble_cnt), 133'(mcnt));
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample just after it
  task automatic drive_edge(input logic iv, input logic [9:0] c, input logic [132:0] d,
                            input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge(iv, c, d, ordy, fl);
    #1;
  endtask

  typedef struct {
    logic         iv;
    logic [9:0]   c;
    logic [132:0] d;
    logic         ordy;
    logic         ev;
    logic [9:0]   ec;
    logic [132:0] ed;
    logic         er;
  } vec_t;
  vec_t tbl[$];

  initial begin
    clrn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_ctrl2 = 10'h3FF; in_data2 = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 133'(out_valid), 133'(0));
    chk("reset out_ctrl", 133'(out_ctrl), 133'(0));
    chk("reset out_data", out_data, 133'(0));
    chk("reset in_ready", 133'(in_ready), 133'(1));
    chk("reset bubble_cnt", 133'(bubble_cnt), 133'(0));
    #2 clrn = 1'b1;

    // Streaming, drain, then backpressure A/B/C
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{1'b1, 10'(i), 133'(i), 1'b1, 1'b1, 10'(i), 133'(i), 1'b1});
    tbl.push_back('{1'b0, 10'h000, 133'h0, 1'b1, 1'b0, 10'h000, 133'h0, 1'b1});
    tbl.push_back('{1'b1, 10'h0A1, 133'hA, 1'b0, 1'b1, 10'h0A1, 133'hA, 1'b1});
    tbl.push_back('{1'b1, 10'h0B2, 133'hB, 1'b0, 1'b1, 10'h0A1, 133'hA, 1'b0});
    tbl.push_back('{1'b1, 10'h0C3, 133'hC, 1'b0, 1'b1, 10'h0A1, 133'hA, 1'b0});
    tbl.push_back('{1'b1, 10'h0C3, 133'hC, 1'b1, 1'b1, 10'h0B2, 133'hB, 1'b1});
    tbl.push_back('{1'b1, 10'h0C3, 133'hC, 1'b1, 1'b1, 10'h0C3, 133'hC, 1'b1});
    tbl.push_back('{1'b0, 10'h000, 133'h0, 1'b1, 1'b0, 10'h000, 133'h0, 1'b1});

    foreach (tbl[k]) begin
      drive_edge(tbl[k].iv, tbl[k].c, tbl[k].d, tbl[k].ordy, 1'b0);
      chk($sformatf("vec%0d out_valid", k), 133'(out_valid), 133'(tbl[k].ev));
      chk($sformatf("vec%0d out_ctrl", k), 133'(out_ctrl), 133'(tbl[k].ec));
      if (tbl[k].ev) chk($sformatf("vec%0d out_data", k), out_data, tbl[k].ed);
      chk($sformatf("vec%0d in_ready", k), 133'(in_ready), 133'(tbl[k].er));
    end

    // Flush with skid full and a beat offered in the same cycle
    drive_edge(1'b1, 10'h111, 133'h11, 1'b0, 1'b0);
    drive_edge(1'b1, 10'h122, 133'h22, 1'b0, 1'b0);
    chk("flush pre in_ready", 133'(in_ready), 133'(0));
    drive_edge(1'b1, 10'h133, 133'h33, 1'b0, 1'b1);
    chk("flush out_valid", 133'(out_valid), 133'(0));
    chk("flush out_ctrl", 133'(out_ctrl), 133'(0));
    chk("flush in_ready", 133'(in_ready), 133'(1));
    drive_edge(1'b1, 10'h155, 133'h55, 1'b1, 1'b0);
    chk("post-flush out_valid", 133'(out_valid), 133'(1));
    chk("post-flush out_ctrl", 133'(out_ctrl), 133'(10'h155));
    chk("post-flush out_data", out_data, 133'h55);
    drive_edge(1'b0, 10'h0, 133'h0, 1'b1, 1'b0);
    chk("post-flush drain", 133'(out_valid), 133'(0));

    // Asynchronous reset mid-transfer, observed without any clock edge
    drive_edge(1'b1, 10'h1AA, 133'hAA, 1'b0, 1'b0);
    drive_edge(1'b1, 10'h1BB, 133'hBB, 1'b0, 1'b0);
    in_ctrl = 10'h3FF;
    clrn = 1'b0;
    #1;
    chk("async out_valid", 133'(out_valid), 133'(0));
    chk("async out_ctrl", 133'(out_ctrl), 133'(0));
    chk("async out_data", out_data, 133'(0));
    chk("async in_ready", 133'(in_ready), 133'(1));
    chk("async bubble_cnt", 133'(bubble_cnt), 133'(0));
    chk("async bubble_cnt sat", 133'(bubble_cnt2), 133'(0));
    model_reset();
    #2 clrn = 1'b1;

    // Starved with all-ones control offered: outputs stay a bubble
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b0, 10'h3FF, 133'h0, 1'b1, 1'b0);
      chk($sformatf("gate%0d out_ctrl", i), 133'(out_ctrl), 133'(0));
    end
    chk("bubble_cnt 5", 133'(bubble_cnt), 133'(5));
    chk("bubble_cnt sat 5", 133'(bubble_cnt2), 133'(5));
    for (int i = 0; i < 5; i++) drive_edge(1'b0, 10'h3FF, 133'h0, 1'b1, 1'b0);
    chk("bubble_cnt 10", 133'(bubble_cnt), 133'(10));
    chk("bubble_cnt sat 7", 133'(bubble_cnt2), 133'(7));

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic [132:0] rd;
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      drive_edge(($urandom_range(0, 9) < 7), 10'($urandom), rd,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
